// File: rtl/frame_load_ctrl.sv
// UART-fed frame loader: waits for a sync byte, writes WIDTH*HEIGHT pixels
// into the back bank, swaps banks on a full frame, aborts on timeout or cancel.
module frame_load_ctrl #(
  parameter int unsigned WIDTH       = 534,
  parameter int unsigned HEIGHT      = 400,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  localparam int unsigned DEPTH      = WIDTH * HEIGHT,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          uart_clk,
  input  logic          rst,
  input  logic          uart_rx_valid,
  input  logic [7:0]    data_in,
  input  logic          abort,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          wr_bank,
  output logic          disp_bank,
  output logic          busy,
  output logic          frame_done,
  output logic          err_timeout,
  output logic [15:0]   frame_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_AT = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state, state_d;
  logic [AW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic sync_hit, take, tmo;

  always_comb begin
    state_d  = state;
    sync_hit = 1'b0;
    take     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (uart_rx_valid && data_in == SYNC_BYTE) begin
          sync_hit = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // abort outranks a coincident byte
        if (abort) begin
          state_d = IDLE;
        end else if (uart_rx_valid) begin
          take = 1'b1;
          if (pcnt == LAST) state_d = DONE;
        end else if (tcnt == TMO_AT) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      disp_bank   <= 1'b0;
      err_timeout <= 1'b0;
      frame_count <= '0;
      pcnt        <= '0;
      tcnt        <= '0;
    end else begin
      state <= state_d;
      wr_en <= take;
      if (take) begin
        wr_addr <= pcnt;
        wr_data <= data_in;
      end
      if (sync_hit) begin
        pcnt <= '0;
        tcnt <= '0;
      end else if (take) begin
        pcnt <= (pcnt == LAST) ? '0 : pcnt + AW'(1);
        tcnt <= '0;
      end else if (state == LOAD) begin
        tcnt <= tcnt + TW'(1);
      end
      if (sync_hit) err_timeout <= 1'b0;
      else if (tmo) err_timeout <= 1'b1;
      // explicit hold keeps the counter a plain register each cycle
      if (state == DONE) begin
        disp_bank   <= ~disp_bank;
        frame_count <= frame_count + 16'd1;
      end else begin
        frame_count <= frame_count;
      end
    end
  end

  assign wr_bank    = ~disp_bank;
  assign busy       = (state == LOAD);
  assign frame_done = (state == DONE);

endmodule

// File: doc/frame_load_ctrl.md
Name: frame_load_ctrl

Overview:
Sequences image uploads from the UART receiver into a double-buffered frame memory on uart_clk. Waits for a sync byte, then forwards exactly WIDTH*HEIGHT pixel bytes as addressed write strobes into the back bank. On a complete frame it swaps display/back banks. It aborts on inter-byte timeout or a host cancel, so a truncated upload never reaches the displayed bank.

Parameters:
WIDTH, 534, image width in pixels
HEIGHT, 400, image height in pixels
SYNC_BYTE, 8'hAA, frame-start marker byte
TIMEOUT_CYC, 1000000, max uart_clk cycles allowed between bytes during LOAD (must be >= 2)
Derived: DEPTH = WIDTH*HEIGHT; AW = $clog2(DEPTH)

Ports:
uart_clk  in  1  sole clock
rst  in  1  synchronous reset, active-high
uart_rx_valid  in  1  one-cycle strobe, data_in valid
data_in  in  8  received byte
abort  in  1  host cancel, level-sampled each cycle
wr_en  out  1  frame-memory write strobe
wr_addr  out  AW  write address, 0..DEPTH-1
wr_data  out  8  write data
wr_bank  out  1  bank being written; always ~disp_bank
disp_bank  out  1  bank the display reads
busy  out  1  high in LOAD
frame_done  out  1  one-cycle pulse on frame completion
err_timeout  out  1  sticky timeout flag
frame_count  out  16  completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rst=1 at a uart_clk edge): state=IDLE. wr_en=0, wr_addr=0, wr_data=0, disp_bank=0, busy=0, frame_done=0, err_timeout=0, frame_count=0, pixel counter=0, timeout counter=0. Reset mid-LOAD discards the partial frame. No bank swap occurs.
- States: IDLE, LOAD, DONE.
- IDLE:
  - uart_rx_valid with data_in==SYNC_BYTE -> LOAD. Clear pixel counter and timeout counter. Clear err_timeout.
  - All other bytes are ignored; no write occurs.
- LOAD: busy=1.
  - Each uart_rx_valid registers wr_en=1, wr_addr=pixel counter, wr_data=data_in on the next cycle. Latency is 1 cycle, and wr_en is high for exactly 1 cycle per byte.
  - The pixel counter then increments.
  - A byte equal to SYNC_BYTE is ordinary pixel data here.
  - When the pixel counter is DEPTH-1 and uart_rx_valid is high, the byte is written and the next state is DONE.
- Timeout counter:
  - Increments each LOAD cycle without uart_rx_valid and clears on uart_rx_valid.
  - Reaching TIMEOUT_CYC-1 with no byte -> IDLE. err_timeout is set to 1. No swap.
- abort=1 in LOAD -> IDLE the next cycle. No error, no swap.
  - If abort and uart_rx_valid are high in the same cycle, abort wins: the byte is dropped and wr_en stays 0.
  - abort in IDLE or DONE has no effect.
- DONE (exactly 1 cycle):
  - frame_done=1 for that cycle.
  - disp_bank toggles.
  - frame_count increments.
  - Next state is IDLE.
  - A byte arriving in DONE is dropped, including SYNC_BYTE.
- wr_addr and wr_data hold their last values while wr_en=0.
- The pixel counter never exceeds DEPTH-1.

Test Plan:
- Use WIDTH=4, HEIGHT=2, TIMEOUT_CYC=16 unless noted.
- Nominal frame: send 0xAA, then bytes 0x10..0x17 spaced 3 cycles apart -> 8 wr_en pulses with addr 0..7 and data 0x10..0x17, each 1 cycle after its strobe. Then frame_done pulses once, disp_bank 0->1, wr_bank 1->0, frame_count=1.
- Pre-sync garbage and in-frame sync: send 0x55, 0x00, then 0xAA, then 8 bytes where byte 3 is 0xAA -> no writes before the sync. The in-frame 0xAA is written at addr 3. The frame completes normally.
- Timeout: sync, 3 bytes, then silence for 20 cycles -> IDLE after 15 idle cycles, err_timeout=1, disp_bank unchanged, frame_count unchanged. A following sync clears err_timeout.
- Abort collision: sync, 2 bytes, then abort coincident with the 3rd byte -> no write for the 3rd byte, IDLE, err_timeout=0, no swap. A fresh full frame then writes from addr 0.
- Reset mid-load: assert rst after 5 bytes -> all outputs return to reset values. Bytes sent without a new sync are ignored.
- Wrap: force frame_count=16'hFFFF and complete a frame -> frame_count=0 and frame_done pulses.
